hazard_control: RTL and testbench

- Pipeline hazard controller for the 5-stage MIPS core. It sits beside the forwarding unit and handles the hazards forwarding cannot resolve:
  - load-use stalls;
  - taken-branch flushes resolved in EX;
  - sequencing of the multi-cycle multiply/divide unit (MDU), including stalling HI/LO readers and structural conflicts while the MDU is busy.
- It drives the PC, IF/ID and ID/EX write-enable and flush controls, and issues MD_Start.

---
 rtl/hazard_pkg.sv | 19 +
 rtl/hazard_control_if.sv | 48 ++++
 rtl/hazard_control_md_busy_timer.sv | 55 +++++
 rtl/hazard_control.sv | 87 ++++++++
 tb/tb_hazard_control.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller: MDU state encoding,
// default MDU latency and the hard-wired zero register.
package hazard_pkg;

  localparam logic ST_RUN     = 1'b0;
  localparam logic ST_MD_BUSY = 1'b1;

  localparam int unsigned MD_LATENCY_DEFAULT = 32;
  localparam int unsigned CNT_W_DEFAULT      = 6;
  localparam int unsigned REG_W              = 5;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    RUN     = ST_RUN,
    MD_BUSY = ST_MD_BUSY
  } mdState_e;

endpackage

// File: rtl/hazard_control_if.sv
// ID/EX hazard inputs and pipeline control outputs of hazard_control.
// Stat_Stalls/Stat_Flushes exist only when HAZARD_STATS_EN is defined.
interface hazard_control_if
`ifdef HAZARD_STATS_EN
  #(parameter int unsigned STAT_W = 32)
`endif
  ;
  import hazard_pkg::*;

  logic [REG_W-1:0] IDRegRs;
  logic [REG_W-1:0] IDRegRt;
  logic             ID_UseRt;
  logic             ID_MulDiv;
  logic             ID_ReadHiLo;
  logic             EX_MemRead;
  logic [REG_W-1:0] EXRegRt;
  logic             EX_BranchTaken;

  logic PCWrite;
  logic IFID_Write;
  logic IFID_Flush;
  logic IDEX_Flush;
  logic MD_Start;
  logic MD_Busy;
`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] Stat_Stalls;
  logic [STAT_W-1:0] Stat_Flushes;
`endif

  modport master (
    output IDRegRs, IDRegRt, ID_UseRt, ID_MulDiv, ID_ReadHiLo,
    output EX_MemRead, EXRegRt, EX_BranchTaken,
`ifdef HAZARD_STATS_EN
    input  Stat_Stalls, Stat_Flushes,
`endif
    input  PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, MD_Start, MD_Busy
  );

  modport slave (
    input  IDRegRs, IDRegRt, ID_UseRt, ID_MulDiv, ID_ReadHiLo,
    input  EX_MemRead, EXRegRt, EX_BranchTaken,
`ifdef HAZARD_STATS_EN
    output Stat_Stalls, Stat_Flushes,
`endif
    output PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, MD_Start, MD_Busy
  );

endinterface

// File: rtl/hazard_control_md_busy_timer.sv
// MDU busy timer: loads LATENCY on start and counts down; busy is high for
// exactly LATENCY cycles after the start cycle.
module md_busy_timer
  import hazard_pkg::*;
#(
  parameter int unsigned LATENCY = MD_LATENCY_DEFAULT,
  parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy
);

  mdState_e          state, stateNext;
  logic [CNT_W-1:0]  mdCnt, mdCntNext;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      mdCnt <= '0;
    end else begin
      state <= stateNext;
      mdCnt <= mdCntNext;
    end
  end

  always_comb begin
    stateNext = state;
    mdCntNext = mdCnt;
    unique case (state)
      RUN: begin
        if (start) begin
          stateNext = MD_BUSY;
          mdCntNext = CNT_W'(LATENCY);
        end
      end
      MD_BUSY: begin
        if (mdCnt == CNT_W'(1)) begin
          stateNext = RUN;
          mdCntNext = '0;
        end else begin
          mdCntNext = mdCnt - CNT_W'(1);
        end
      end
      default: begin
        stateNext = RUN;
        mdCntNext = '0;
      end
    endcase
  end

  assign busy = (state == MD_BUSY);

endmodule

// File: rtl/hazard_control.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and MDU
// sequencing. Define HAZARD_STATS_EN to add stall/flush event counters.
module hazard_control
  import hazard_pkg::*;
#(
  parameter int unsigned MD_LATENCY = MD_LATENCY_DEFAULT,
  parameter int unsigned CNT_W      = CNT_W_DEFAULT
`ifdef HAZARD_STATS_EN
  , parameter int unsigned STAT_W   = 32
`endif
) (
  input logic              clk,
  input logic              reset,
  hazard_control_if.slave  hz
);

  logic ldHaz;
  logic mdHaz;
  logic flush;
  logic stall;
  logic mdStart;
  logic mdBusy;

  // $0 is hard-wired, so a load targeting it never creates a real dependency
  assign ldHaz = hz.EX_MemRead && (hz.EXRegRt != REG_ZERO) &&
                 ((hz.EXRegRt == hz.IDRegRs) ||
                  (hz.ID_UseRt && (hz.EXRegRt == hz.IDRegRt)));
  assign mdHaz = mdBusy && (hz.ID_ReadHiLo || hz.ID_MulDiv);

  // Wrong-path ID instruction on a taken branch, so its stalls are moot
  assign flush   = !reset && hz.EX_BranchTaken;
  assign stall   = !reset && !hz.EX_BranchTaken && (mdHaz || ldHaz);
  assign mdStart = !reset && !hz.EX_BranchTaken && !(mdHaz || ldHaz) && hz.ID_MulDiv;

  md_busy_timer #(
    .LATENCY (MD_LATENCY),
    .CNT_W   (CNT_W)
  ) u_md_busy_timer (
    .clk   (clk),
    .reset (reset),
    .start (mdStart),
    .busy  (mdBusy)
  );

  always_comb begin
    hz.PCWrite    = 1'b1;
    hz.IFID_Write = 1'b1;
    hz.IFID_Flush = 1'b0;
    hz.IDEX_Flush = 1'b0;
    if (reset) begin
      hz.PCWrite    = 1'b0;
      hz.IFID_Write = 1'b0;
      hz.IFID_Flush = 1'b1;
      hz.IDEX_Flush = 1'b1;
    end else if (flush) begin
      hz.IFID_Flush = 1'b1;
      hz.IDEX_Flush = 1'b1;
    end else if (stall) begin
      hz.PCWrite    = 1'b0;
      hz.IFID_Write = 1'b0;
      hz.IDEX_Flush = 1'b1;
    end
  end

  assign hz.MD_Start = mdStart;
  // An abandoned MDU op is hidden as soon as reset is asserted
  assign hz.MD_Busy  = mdBusy && !reset;

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] statStalls;
  logic [STAT_W-1:0] statFlushes;

  always_ff @(posedge clk) begin
    if (reset) begin
      statStalls  <= '0;
      statFlushes <= '0;
    end else begin
      if (stall) statStalls  <= statStalls + STAT_W'(1);
      if (flush) statFlushes <= statFlushes + STAT_W'(1);
    end
  end

  assign hz.Stat_Stalls  = statStalls;
  assign hz.Stat_Flushes = statFlushes;
`endif

endmodule

// File: tb/tb_hazard_control.sv
// Bench for hazard_control: directed hazard scenarios followed by random
// traffic, compared against a cycle-level reference model.
module tb_hazard_control;
  import hazard_pkg::*;

  localparam int unsigned LAT    = 4;
  localparam int unsigned STAT_W = 32;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  // Reference model state: cycles of MDU busy still to come, event counts
  int   busyLeft = 0;
  int   nStalls  = 0;
  int   nFlushes = 0;

`ifdef HAZARD_STATS_EN
  hazard_control_if #(.STAT_W(STAT_W)) hz ();
  hazard_control #(.MD_LATENCY(LAT), .CNT_W(6), .STAT_W(STAT_W)) dut (
    .clk (clk), .reset (reset), .hz (hz.slave));
`else
  hazard_control_if hz ();
  hazard_control #(.MD_LATENCY(LAT), .CNT_W(6)) dut (
    .clk (clk), .reset (reset), .hz (hz.slave));
`endif

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check just after, advance model at posedge
  task automatic cyc(input string tag, input logic r,
                     input int rs, input int rt, input logic useRt,
                     input logic mulDiv, input logic readHiLo,
                     input logic memRead, input int exRt, input logic br);
    logic busy, ld, mdh, expPc, expIw, expIf, expIdf, expMs, expMb;
    @(negedge clk);
    reset             = r;
    hz.IDRegRs        = 5'(rs);
    hz.IDRegRt        = 5'(rt);
    hz.ID_UseRt       = useRt;
    hz.ID_MulDiv      = mulDiv;
    hz.ID_ReadHiLo    = readHiLo;
    hz.EX_MemRead     = memRead;
    hz.EXRegRt        = 5'(exRt);
    hz.EX_BranchTaken = br;
    #1;
    busy = (busyLeft > 0);
    ld   = memRead && (exRt != 0) && ((exRt == rs) || (useRt && (exRt == rt)));
    mdh  = busy && (readHiLo || mulDiv);
    if (r) begin
      {expPc, expIw, expIf, expIdf, expMs, expMb} = 6'b001100;
    end else if (br) begin
      {expPc, expIw, expIf, expIdf, expMs} = 5'b11110;
      expMb = busy;
    end else if (ld || mdh) begin
      {expPc, expIw, expIf, expIdf, expMs} = 5'b00010;
      expMb = busy;
    end else begin
      {expPc, expIw, expIf, expIdf} = 4'b1100;
      expMs = mulDiv;
      expMb = busy;
    end
    chk({tag, ".PCWrite"},    32'(hz.PCWrite),    32'(expPc));
    chk({tag, ".IFID_Write"}, 32'(hz.IFID_Write), 32'(expIw));
    chk({tag, ".IFID_Flush"}, 32'(hz.IFID_Flush), 32'(expIf));
    chk({tag, ".IDEX_Flush"}, 32'(hz.IDEX_Flush), 32'(expIdf));
    chk({tag, ".MD_Start"},   32'(hz.MD_Start),   32'(expMs));
    chk({tag, ".MD_Busy"},    32'(hz.MD_Busy),    32'(expMb));
`ifdef HAZARD_STATS_EN
    chk({tag, ".Stat_Stalls"},  hz.Stat_Stalls,  32'(nStalls));
    chk({tag, ".Stat_Flushes"}, hz.Stat_Flushes, 32'(nFlushes));
`endif
    @(posedge clk);
    if (r) begin
      busyLeft = 0; nStalls = 0; nFlushes = 0;
    end else begin
      if (br) nFlushes++;
      else if (ld || mdh) nStalls++;
      if (expMs) busyLeft = LAT;
      else if (busyLeft > 0) busyLeft--;
    end
  endtask

  task automatic idle(input string tag);
    cyc(tag, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    // Reset values
    cyc("rst0", 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    cyc("rst1", 1'b1, 3, 4, 1'b1, 1'b1, 1'b0, 1'b1, 3, 1'b0);
    idle("idle");

    // Load-use on rs: exactly one stall cycle, then bubble in EX
    cyc("lduse_rs",  1'b0, 2, 7, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0);
    cyc("lduse_rel", 1'b0, 2, 7, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    // rt match only counts when rt is a source
    cyc("lduse_rt",   1'b0, 1, 9, 1'b1, 1'b0, 1'b0, 1'b1, 9, 1'b0);
    cyc("ld_rt_nouse",1'b0, 1, 9, 1'b0, 1'b0, 1'b0, 1'b1, 9, 1'b0);
    // $0 never stalls
    cyc("ld_zero",   1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);

    // MDU start then mfhi stalled for LAT cycles
    cyc("md_start", 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 1; i <= LAT + 1; i++)
      cyc($sformatf("mfhi_c%0d", i), 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);

    // Branch beats load stall and MDU start
    cyc("br_beats", 1'b0, 5, 0, 1'b0, 1'b1, 1'b0, 1'b1, 5, 1'b1);
    // Branch during MDU busy leaves the countdown alone
    cyc("md_start2", 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    cyc("br_busy",   1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1);
    for (int i = 2; i <= LAT + 1; i++)
      cyc($sformatf("md2_c%0d", i), 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    // That final cycle started a new op; combined ld+md hazard stalls once per cycle
    cyc("combo", 1'b0, 6, 0, 1'b0, 1'b0, 1'b1, 1'b1, 6, 1'b0);
    for (int i = 0; i < LAT; i++) idle("drain");

    // Reset in the middle of an MDU op
    cyc("md_start3", 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    idle("busy_c1");
    cyc("rst_mid",   1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    cyc("post_rst",  1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);

    // Three load stalls and two flushes for the event counters
    for (int i = 0; i < 3; i++) begin
      cyc("st_ld",  1'b0, 4, 0, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b0);
      idle("st_gap");
    end
    cyc("st_br", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    cyc("st_br", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    idle("st_chk");
    cyc("st_rst", 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    idle("st_clr");

    // Random traffic over a small register range to hit matches often
    for (int i = 0; i < 400; i++) begin
      cyc("rand", ($urandom_range(0, 49) == 0),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
